// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: loads a 64-bit key through PC-1 and hands out the
// 16 PC-2 subkeys one per valid/ready handshake, in encrypt or decrypt order.
module des_key_schedule #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:64] key_in,
  input  logic        decrypt,
  input  logic        start,
  output logic        key_ready,
  output logic [1:48] subkey,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [3:0]  round_idx,
  output logic        done,
  output logic        parity_err
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam int PC1 [1:56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [1:48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Bit r set means round r+1 rotates by two; rounds 1, 2, 9 and 16 rotate by one.
  localparam logic [15:0] SHIFT2 = 16'h7EFC;

  function automatic logic [1:56] pc1(input logic [1:64] k);
    logic [1:56] r;
    for (int i = 1; i <= 56; i++) r[i] = k[PC1[i]];
    return r;
  endfunction

  function automatic logic [1:48] pc2(input logic [1:28] c, input logic [1:28] d);
    logic [1:56] cd;
    logic [1:48] r;
    cd = {c, d};
    for (int i = 1; i <= 48; i++) r[i] = cd[PC2[i]];
    return r;
  endfunction

  function automatic logic [1:28] rotl(input logic [1:28] x, input logic two);
    return two ? {x[3:28], x[1:2]} : {x[2:28], x[1]};
  endfunction

  function automatic logic [1:28] rotr(input logic [1:28] x, input logic two);
    return two ? {x[27:28], x[1:26]} : {x[28], x[1:27]};
  endfunction

  state_t      state;
  logic [1:28] c_q;
  logic [1:28] d_q;
  logic        dir_q;

  logic [1:56] key_pc1;
  logic [3:0]  idx_next;
  logic [3:0]  idx_prev;
  logic        enc_two;
  logic        dec_two;
  logic        last;
  logic        parity_bad;

  assign key_pc1  = pc1(key_in);
  assign idx_next = round_idx + 4'd1;
  assign idx_prev = round_idx - 4'd1;
  // Encrypt steps into the next round's shift; decrypt undoes the current one.
  assign enc_two  = SHIFT2[idx_next];
  assign dec_two  = SHIFT2[round_idx];
  assign last     = dir_q ? (round_idx == 4'd0) : (round_idx == 4'd15);
  assign subkey   = pc2(c_q, d_q);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    parity_bad = 1'b0;
    for (int b = 0; b < 8; b++)
      if (!(^key_in[8*b+1 +: 8])) parity_bad = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side reads the pre-edge value regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      c_q          <= '0;
      d_q          <= '0;
      dir_q        <= 1'b0;
      key_ready    <= 1'b1;
      subkey_valid <= 1'b0;
      round_idx    <= 4'd0;
      done         <= 1'b0;
      parity_err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && key_ready) begin
            // Decrypt starts at C16,D16, which equals the unrotated PC-1 output.
            c_q          <= decrypt ? key_pc1[1:28]  : rotl(key_pc1[1:28], 1'b0);
            d_q          <= decrypt ? key_pc1[29:56] : rotl(key_pc1[29:56], 1'b0);
            round_idx    <= decrypt ? 4'd15 : 4'd0;
            dir_q        <= decrypt;
            parity_err   <= CHECK_PARITY && parity_bad;
            key_ready    <= 1'b0;
            subkey_valid <= 1'b1;
            state        <= EMIT;
          end
        end
        EMIT: begin
          if (subkey_ready) begin
            if (last) begin
              key_ready    <= 1'b1;
              subkey_valid <= 1'b0;
              done         <= 1'b1;
              state        <= IDLE;
            end else if (dir_q) begin
              c_q       <= rotr(c_q, dec_two);
              d_q       <= rotr(d_q, dec_two);
              round_idx <= idx_prev;
            end else begin
              c_q       <= rotl(c_q, enc_two);
              d_q       <= rotl(d_q, enc_two);
              round_idx <= idx_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES subkey generator.
- Accepts a 64-bit key, applies PC-1, then performs the per-round C/D rotations.
- Emits the 16 48-bit PC-2 subkeys one per handshake, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Sits directly upstream of the round datapath and drives its 48-bit round-key input. Rounds consume subkeys in lockstep with the round counter.

Parameters:
- CHECK_PARITY, 0, when 1 the odd-parity of each key byte (bits 8,16,..,64 as parity) is checked at load and reported on parity_err; when 0 parity_err is tied 0.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- key_in  input  [1:64]  DES key; bit 1 = MSB; parity bits ignored by PC-1
- decrypt  input  1  sampled with start; 1 = emit K16 first
- start  input  1  load request; accepted only when key_ready=1
- key_ready  output  1  high in IDLE; start accepted when start&key_ready
- subkey  output  [1:48]  PC-2(C,D) of current round; bit 1 = MSB
- subkey_valid  output  1  subkey/round_idx valid
- subkey_ready  input  1  consumer accepts subkey when subkey_valid&subkey_ready
- round_idx  output  4  subkey index minus 1 (0 = K1 .. 15 = K16)
- done  output  1  one-cycle pulse the cycle after the last subkey is accepted
- parity_err  output  1  registered at load; held until next accepted start

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, C=D=0, key_ready=1, subkey_valid=0.
  - round_idx=0, done=0, parity_err=0.
  - subkey = PC-2(0,0) = 0.
- States: IDLE, EMIT.
- IDLE, on start & key_ready:
  - C,D <= PC-1(key_in) halves (28 bits each).
  - Encrypt: C,D are additionally rotated left by 1, giving C1,D1. round_idx<=0.
  - Decrypt: C,D are not rotated (C0=C16). round_idx<=15.
  - dir <= decrypt.
  - parity_err <= CHECK_PARITY & (any key byte has even weight).
  - Go to EMIT.
- Latency: subkey_valid rises on the cycle after start is accepted.
- EMIT:
  - subkey_valid=1, key_ready=0.
  - subkey is combinational PC-2 of the registered C,D (no extra register).
- Shift table, rounds 1..16: 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- On accept (subkey_valid & subkey_ready), where i = round_idx+1:
  - Encrypt, i<16: rotate C,D left by shift[i+1]; round_idx+1.
  - Decrypt, i>1: rotate C,D right by shift[i]; round_idx-1.
  - Last subkey (encrypt i=16, decrypt i=1): go to IDLE, assert done for exactly one cycle, and rotate C,D no further.
- Stall: while subkey_ready=0, C, D, round_idx and subkey hold stable. subkey_valid must not drop until accepted.
- start while in EMIT: ignored; no effect on state, dir, C/D or parity_err.
- decrypt and key_in are sampled only at the accepting edge; later changes have no effect.
- done and key_ready=1 coincide in the cycle after the final accept.
  - A start in that same cycle is accepted.
  - Back-to-back keys therefore cost 1 idle cycle between bursts: K16 of key A is accepted at cycle t, key B is loaded at t+1, and key B's K1 is valid at t+2.
- Reset mid-burst: returns to IDLE immediately. No done is generated and parity_err clears.
- Rotations are cyclic within each 28-bit half: bit 1 wraps to bit 28 on left rotate, and the reverse on right rotate.
- After 16 encrypt rotations (total 28 per half), C,D equal PC-1 output. Verification checks this as an internal assertion.

Test Plan:
- Encrypt, key_in=0x133457799BBCDFF1, decrypt=0, subkey_ready=1 constant:
  - subkey_valid rises 1 cycle after start.
  - K1=0x1B02EFFC7072, K16=0xCB3D8B0E17F5.
  - round_idx steps 0..15; done pulses the cycle after K16. All 16 subkeys match the reference model.
- Decrypt, same key, decrypt=1:
  - First subkey=0xCB3D8B0E17F5 (round_idx=15), last subkey=0x1B02EFFC7072 (round_idx=0).
  - The sequence is the exact reverse of the encrypt run.
- Backpressure: subkey_ready toggles pseudo-randomly (including holding 0 for 5 cycles on K9):
  - subkey/round_idx stay stable during the stall.
  - No subkey is skipped or duplicated; total accepts = 16.
- start pulsed during EMIT with a different key/decrypt:
  - Ignored; the burst completes with the original key's values.
  - A new start in the done cycle is accepted, and the next K1 is valid 1 cycle later.
- CHECK_PARITY=1:
  - key 0x133457799BBCDFF1 -> parity_err=0.
  - key 0x0000000000000000 -> parity_err=1 and all 16 subkeys are 0.
  - With CHECK_PARITY=0, parity_err stays 0 for both keys.
- Async reset asserted at round_idx=7 (mid-clock):
  - Outputs go immediately to the reset values: subkey_valid=0, key_ready=1, done=0.
  - After release, a fresh start produces the correct K1.
